// File: rtl/dcache_responder.sv
// ============================================================================
// Module   : dcache_responder
// Brief    : Direct-mapped, write-through, no-write-allocate data cache with
//            LL/SC link register, answering datapath MEM-stage requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_responder #(
    parameter int SETS   = 16,
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              halt,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic              datomic,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              flushed,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    input  logic              dwait,
    input  logic [WORD_W-1:0] dload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WORD_W - IDX_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RFILL  = 2'd1,
        WRITE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS];

    logic              link_valid;
    logic [WORD_W-3:0] link_addr;

    logic [IDX_W-1:0]  index;
    logic [TAG_W-1:0]  tag;
    logic [WORD_W-3:0] word_addr;
    logic              hit;
    logic              sc_ok;
    logic              fill_en;
    logic              upd_en;
    logic              set_link;
    logic              clr_link;
    logic              unused_lsb;

    assign index      = dmemaddr[IDX_W+1:2];
    assign tag        = dmemaddr[WORD_W-1:IDX_W+2];
    assign word_addr  = dmemaddr[WORD_W-1:2];
    assign hit        = valid[index] && (tags[index] == tag);
    assign sc_ok      = link_valid && (link_addr == word_addr);
    assign unused_lsb = ^dmemaddr[1:0];

    always_comb begin
        state_next = state;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = '0;
        dstore     = '0;
        fill_en    = 1'b0;
        upd_en     = 1'b0;
        set_link   = 1'b0;
        clr_link   = 1'b0;

        case (state)
            IDLE: begin
                if (halt) begin
                    state_next = HALTED;
                end else if (dmemWEN) begin
                    if (datomic && !sc_ok) begin
                        // Failed SC resolves locally without touching memory.
                        dhit     = 1'b1;
                        clr_link = 1'b1;
                    end else begin
                        state_next = WRITE;
                    end
                end else if (dmemREN) begin
                    if (hit) begin
                        dhit     = 1'b1;
                        dmemload = data[index];
                        set_link = datomic;
                    end else begin
                        state_next = RFILL;
                    end
                end
            end

            RFILL: begin
                dREN  = 1'b1;
                daddr = {word_addr, 2'b00};
                if (!dwait) begin
                    dhit       = 1'b1;
                    dmemload   = dload;
                    fill_en    = 1'b1;
                    set_link   = datomic;
                    state_next = IDLE;
                end
            end

            WRITE: begin
                dWEN   = 1'b1;
                daddr  = {word_addr, 2'b00};
                dstore = dmemstore;
                if (!dwait) begin
                    dhit       = 1'b1;
                    dmemload   = WORD_W'(datomic);
                    upd_en     = hit;
                    clr_link   = datomic || (link_addr == word_addr);
                    state_next = IDLE;
                end
            end

            HALTED: begin
                flushed = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            valid      <= '0;
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else begin
            state <= state_next;
            if (fill_en) begin
                valid[index] <= 1'b1;
            end
            // A new link takes precedence over any coincident invalidation.
            if (set_link) begin
                link_valid <= 1'b1;
                link_addr  <= word_addr;
            end else if (clr_link) begin
                link_valid <= 1'b0;
            end
        end
    end

    // Tag and data storage need no reset; valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (fill_en) begin
                tags[index] <= tag;
                data[index] <= dload;
            end else if (upd_en) begin
                data[index] <= dmemstore;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/dcache_responder.md
Name: dcache_responder

Overview:
- Data-side responder for the datapath/cache interface. It answers the pipeline's dmemREN/dmemWEN/datomic requests with dhit and dmemload.
- Direct-mapped, one-word-per-line, write-through, no-write-allocate cache.
- Sits between the pipelined datapath's MEM stage and the memory controller's data port.
- Provides the LL/SC link register for atomic support, and raises flushed once the datapath signals halt.

Parameters:
SETS, 16, number of cache lines (power of 2); IDX_W = log2(SETS)
WORD_W, 32, data and address width

Ports:
CLK  in  1  system clock; all state updates on posedge
RST  in  1  synchronous, active-high reset
halt  in  1  datapath halt (sticky from datapath)
dmemREN  in  1  load request (LL when datomic=1)
dmemWEN  in  1  store request (SC when datomic=1)
datomic  in  1  marks request as LL/SC
dmemaddr  in  32  byte address; [1:0] ignored
dmemstore  in  32  store data
dhit  out  1  request complete this cycle
dmemload  out  32  load data / SC result
flushed  out  1  cache quiesced after halt
dREN  out  1  memory read request
dWEN  out  1  memory write request
daddr  out  32  memory address, word aligned ({dmemaddr[31:2],2'b00})
dstore  out  32  memory write data
dwait  in  1  memory busy; transfer completes in the cycle dwait=0
dload  in  32  memory read data

Behaviour:
- Address split: index = dmemaddr[IDX_W+1:2]; tag = dmemaddr[31:IDX_W+2].
- Each line holds a valid bit, a tag and a 32-bit data word.
- FSM states: IDLE, RFILL, WRITE, HALTED.
- Reset (RST=1 at posedge):
  - state=IDLE; all valid bits=0; link_valid=0.
  - Outputs next cycle: dhit=0, dmemload=0, dREN=0, dWEN=0, daddr=0, dstore=0, flushed=0.
  - Reset mid-RFILL/WRITE abandons the transfer. No line is written.
- IDLE:
  - If halt=1 → HALTED; no request is serviced in that cycle.
  - dmemWEN has priority over dmemREN if both are asserted.
  - Read hit (REN, valid, tag match): dhit=1 combinationally in the same cycle; dmemload=line data; state stays IDLE. Zero-cycle latency.
  - Read miss → RFILL.
  - Non-atomic write → WRITE.
  - SC with link_valid=1 and link_addr=dmemaddr[31:2] → WRITE.
  - SC failing the link check: dhit=1 same cycle; dmemload=0; no memory access; link_valid cleared.
- RFILL:
  - dREN=1, daddr=aligned dmemaddr.
  - On cycle with dwait=0: dhit=1, dmemload=dload; line[index] ← {valid=1, tag, dload}; → IDLE.
- WRITE:
  - dWEN=1, daddr aligned, dstore=dmemstore.
  - On cycle with dwait=0:
    - dhit=1.
    - If line[index] is valid with matching tag, its data ← dmemstore (write-update); on a miss the line is unchanged.
    - dmemload=1 if the request is an SC, else 0.
    - → IDLE.
- Miss and write latency = memory latency (cycles of dwait=1) + 1.
- While dwait=1, the FSM holds and dREN/dWEN/daddr/dstore stay stable.
- The requester holds the request until dhit. Inputs changing mid-transfer are a protocol violation; daddr/dstore are driven from the live inputs.
- Link register:
  - LL completion (dhit on REN with datomic) sets link_valid=1 and link_addr=dmemaddr[31:2]. This applies to both hit and fill.
  - Any completing write (plain store or successful SC) whose dmemaddr[31:2] equals link_addr clears link_valid.
  - A successful SC always clears link_valid.
  - If LL and a clearing event coincide, LL wins.
- HALTED:
  - dhit=0; dREN=dWEN=0; flushed=1 from the first cycle in HALTED.
  - The cache is write-through, so nothing is written back.
  - Held until RST.
- dhit is never asserted without a pending dmemREN or dmemWEN.

Test Plan:
- Reset, LW 0x40 with 2 wait cycles, dload=0xDEADBEEF → dREN high 3 cycles, dhit in 3rd cycle with dmemload=0xDEADBEEF. Repeat LW 0x40 → dhit same cycle, no dREN.
- SW 0x40 data 0x12345678 after the fill, dwait=0 → dWEN 1 cycle, dhit. Then LW 0x40 → hit returning 0x12345678. A conflicting LW at 0x440 (same index) → miss, refill.
- LL 0x80, then SC 0x80 data 5 → dWEN issued, dhit with dmemload=1, link_valid=0. Second SC 0x80 → immediate dhit, dmemload=0, no dWEN.
- LL 0x80, SW 0x80 data 7, SC 0x80 → SC fails (dmemload=0, no dWEN). Repeat with the SW at 0x84 instead → SC succeeds.
- Assert RST during RFILL with dwait=1 → next cycle dREN=0, state IDLE. A following LW to the same address misses.
- Assert halt in IDLE with dmemREN pending → no dhit; flushed=1 next cycle; dREN/dWEN stay 0 for 10 cycles.
